// File: rtl/reg_cregfile_unit.sv
// Architectural register storage for the decode stage: 32x32 GPR file with two
// registered read ports and two write ports, plus the control-register file.
module reg_cregfile_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  s_1,
  output logic [31:0] d_1,
  input  logic [4:0]  s_2,
  output logic [31:0] d_2,
  input  logic        we1,
  input  logic [4:0]  target_1,
  input  logic [31:0] write_data_1,
  input  logic        we2,
  input  logic [4:0]  target_2,
  input  logic [31:0] write_data_2,
  input  logic        stall,
  output logic [31:0] ret_val,
  input  logic [4:0]  cr_s,
  output logic [31:0] cr_d,
  input  logic        cr_we,
  input  logic        exc_in_wb,
  input  logic        tlb_exc_in_wb,
  input  logic [31:0] tlb_addr,
  input  logic [31:0] epc,
  input  logic [31:0] efg,
  input  logic [15:0] interrupts,
  input  logic        interrupt_in_wb,
  input  logic        rfe_in_wb,
  input  logic        rfi_in_wb,
  output logic        kmode,
  output logic [31:0] cdv,
  output logic [31:0] interrupt_state,
  output logic [11:0] pid
);

  logic [31:0] gpr [32];

  // Port 1 is checked first so it wins when both ports target the same register.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_gpr
      if (gi == 0) begin : g_r0
        assign gpr[gi] = '0;
      end else begin : g_rn
        logic [31:0] q_reg;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            q_reg <= '0;
          end else if (we1 && target_1 == 5'(gi)) begin
            q_reg <= write_data_1;
          end else if (we2 && target_2 == 5'(gi)) begin
            q_reg <= write_data_2;
          end
        end
        assign gpr[gi] = q_reg;
      end
    end
  endgenerate

  logic [31:0] d_1_next, d_2_next;

  always_comb begin
    d_1_next = gpr[s_1];
    if (s_1 == 5'd0)                     d_1_next = '0;
    else if (we1 && target_1 == s_1)     d_1_next = write_data_1;
    else if (we2 && target_2 == s_1)     d_1_next = write_data_2;

    d_2_next = gpr[s_2];
    if (s_2 == 5'd0)                     d_2_next = '0;
    else if (we1 && target_1 == s_2)     d_2_next = write_data_1;
    else if (we2 && target_2 == s_2)     d_2_next = write_data_2;
  end

  assign ret_val = gpr[1];

  logic [31:0] psr_reg, pid_reg, isr_reg, imr_reg;
  logic [31:0] epc_reg, efg_reg, cdv_reg, tlba_reg;

  logic        trap;
  logic        any_event;
  logic        cr_wr;
  logic [31:0] irq_state;
  logic [15:0] clr_mask;
  logic        clr_found;
  logic [31:0] cr_view;
  logic [31:0] cr_d_next;

  assign trap      = exc_in_wb | tlb_exc_in_wb;
  assign any_event = interrupt_in_wb | trap | rfe_in_wb | rfi_in_wb;
  assign cr_wr     = cr_we & ~any_event;
  assign irq_state = imr_reg[31] ? {16'b0, isr_reg[15:0] & imr_reg[15:0]} : 32'b0;

  // Only the highest-numbered pending enabled interrupt is acknowledged.
  always_comb begin
    clr_mask  = '0;
    clr_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (irq_state[i] && !clr_found) begin
        clr_mask[i] = 1'b1;
        clr_found   = 1'b1;
      end
    end
  end

  always_comb begin
    case (cr_s)
      5'd0:    cr_view = psr_reg;
      5'd1:    cr_view = pid_reg;
      5'd2:    cr_view = isr_reg;
      5'd3:    cr_view = imr_reg;
      5'd4:    cr_view = epc_reg;
      5'd5:    cr_view = efg_reg;
      5'd6:    cr_view = cdv_reg;
      5'd7:    cr_view = tlba_reg;
      default: cr_view = '0;
    endcase
    cr_d_next = cr_view;
    if (cr_s[4:3] != 2'b00)                  cr_d_next = '0;
    else if (cr_wr && target_1 == cr_s)      cr_d_next = write_data_1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psr_reg  <= 32'd1;
      pid_reg  <= '0;
      isr_reg  <= '0;
      imr_reg  <= '0;
      epc_reg  <= '0;
      efg_reg  <= '0;
      cdv_reg  <= '0;
      tlba_reg <= '0;
    end else begin
      isr_reg <= isr_reg | {16'b0, interrupts};
      if (interrupt_in_wb) begin
        epc_reg     <= epc;
        efg_reg     <= efg;
        psr_reg     <= {psr_reg[31:2], psr_reg[0], 1'b1};
        imr_reg[31] <= 1'b0;
        // A line still asserted re-pends through the OR.
        isr_reg     <= (isr_reg & ~{16'b0, clr_mask}) | {16'b0, interrupts};
      end else if (trap) begin
        epc_reg <= epc;
        efg_reg <= efg;
        psr_reg <= {psr_reg[31:2], psr_reg[0], 1'b1};
        if (tlb_exc_in_wb) tlba_reg <= tlb_addr;
      end else if (rfe_in_wb) begin
        psr_reg[0] <= psr_reg[1];
      end else if (rfi_in_wb) begin
        psr_reg[0]  <= psr_reg[1];
        imr_reg[31] <= 1'b1;
      end else if (cr_we) begin
        case (target_1)
          5'd0:    psr_reg  <= write_data_1;
          5'd1:    pid_reg  <= write_data_1;
          5'd2:    isr_reg  <= write_data_1;
          5'd3:    imr_reg  <= write_data_1;
          5'd4:    epc_reg  <= write_data_1;
          5'd5:    efg_reg  <= write_data_1;
          5'd6:    cdv_reg  <= write_data_1;
          5'd7:    tlba_reg <= write_data_1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_1  <= '0;
      d_2  <= '0;
      cr_d <= '0;
    end else if (!stall) begin
      d_1  <= d_1_next;
      d_2  <= d_2_next;
      cr_d <= cr_d_next;
    end
  end

  assign kmode           = psr_reg[0];
  assign cdv             = cdv_reg;
  assign pid             = pid_reg[11:0];
  assign interrupt_state = irq_state;

endmodule

// File: tb/tb_reg_cregfile_unit.sv
// Directed bench for reg_cregfile_unit: behavioural register/CR model checked on
// every cycle, plus literal expectations at key points of the sequence.
module tb_reg_cregfile_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  s_1, s_2, target_1, target_2, cr_s;
  logic [31:0] d_1, d_2, write_data_1, write_data_2, ret_val, cr_d;
  logic        we1, we2, stall, cr_we, exc_in_wb, tlb_exc_in_wb;
  logic [31:0] tlb_addr, epc, efg, cdv, interrupt_state;
  logic [15:0] interrupts;
  logic        interrupt_in_wb, rfe_in_wb, rfi_in_wb, kmode;
  logic [11:0] pid;

  int checks = 0;
  int errors = 0;

  reg_cregfile_unit dut (
    .clk(clk), .rst_n(rst_n),
    .s_1(s_1), .d_1(d_1), .s_2(s_2), .d_2(d_2),
    .we1(we1), .target_1(target_1), .write_data_1(write_data_1),
    .we2(we2), .target_2(target_2), .write_data_2(write_data_2),
    .stall(stall), .ret_val(ret_val),
    .cr_s(cr_s), .cr_d(cr_d), .cr_we(cr_we),
    .exc_in_wb(exc_in_wb), .tlb_exc_in_wb(tlb_exc_in_wb), .tlb_addr(tlb_addr),
    .epc(epc), .efg(efg), .interrupts(interrupts),
    .interrupt_in_wb(interrupt_in_wb), .rfe_in_wb(rfe_in_wb), .rfi_in_wb(rfi_in_wb),
    .kmode(kmode), .cdv(cdv), .interrupt_state(interrupt_state), .pid(pid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_gpr [32];
  logic [31:0] m_cr  [8];
  logic [31:0] m_d1, m_d2, m_crd;
  bit          m_valid = 0;

  function automatic logic [15:0] m_pend();
    return m_cr[3][31] ? (m_cr[2][15:0] & m_cr[3][15:0]) : 16'h0;
  endfunction

  function automatic logic [31:0] m_gread(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we1 && target_1 == a) return write_data_1;
    if (we2 && target_2 == a) return write_data_2;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] m_cread(input logic [4:0] a);
    bit committed;
    committed = cr_we && !(interrupt_in_wb || exc_in_wb || tlb_exc_in_wb || rfe_in_wb || rfi_in_wb);
    if (a >= 8) return 32'h0;
    if (committed && target_1 == a) return write_data_1;
    return m_cr[a[2:0]];
  endfunction

  always @(posedge clk) begin
    logic [31:0] isr_new;
    logic [15:0] pend;
    bit          done;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 0;
      for (int i = 0; i < 8; i++)  m_cr[i] = 0;
      m_cr[0] = 1;
      m_d1 = 0; m_d2 = 0; m_crd = 0;
      m_valid = 1;
    end else begin
      if (!stall) begin
        m_d1  = m_gread(s_1);
        m_d2  = m_gread(s_2);
        m_crd = m_cread(cr_s);
      end
      if (we2 && target_2 != 0) m_gpr[target_2] = write_data_2;
      if (we1 && target_1 != 0) m_gpr[target_1] = write_data_1;
      pend    = m_pend();
      isr_new = m_cr[2] | {16'h0, interrupts};
      if (interrupt_in_wb) begin
        m_cr[4] = epc; m_cr[5] = efg;
        m_cr[0][1] = m_cr[0][0]; m_cr[0][0] = 1'b1;
        m_cr[3][31] = 1'b0;
        done = 0;
        for (int b = 15; b >= 0; b--)
          if (pend[b] && !done) begin
            isr_new = (m_cr[2] & ~(32'h1 << b)) | {16'h0, interrupts};
            done = 1;
          end
      end else if (exc_in_wb || tlb_exc_in_wb) begin
        m_cr[4] = epc; m_cr[5] = efg;
        m_cr[0][1] = m_cr[0][0]; m_cr[0][0] = 1'b1;
        if (tlb_exc_in_wb) m_cr[7] = tlb_addr;
      end else if (rfe_in_wb) begin
        m_cr[0][0] = m_cr[0][1];
      end else if (rfi_in_wb) begin
        m_cr[0][0] = m_cr[0][1];
        m_cr[3][31] = 1'b1;
      end else if (cr_we && target_1 < 8) begin
        if (target_1 == 2) isr_new = write_data_1;
        else m_cr[target_1[2:0]] = write_data_1;
      end
      m_cr[2] = isr_new;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("d_1", d_1, m_d1);
      chk("d_2", d_2, m_d2);
      chk("cr_d", cr_d, m_crd);
      chk("ret_val", ret_val, m_gpr[1]);
      chk("kmode", {31'b0, kmode}, {31'b0, m_cr[0][0]});
      chk("cdv", cdv, m_cr[6]);
      chk("pid", {20'b0, pid}, {20'b0, m_cr[1][11:0]});
      chk("interrupt_state", interrupt_state, {16'h0, m_pend()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; s_1 = 0; s_2 = 0; target_1 = 0; target_2 = 0; cr_s = 0;
    write_data_1 = 0; write_data_2 = 0; we1 = 0; we2 = 0; stall = 0; cr_we = 0;
    exc_in_wb = 0; tlb_exc_in_wb = 0; tlb_addr = 0; epc = 0; efg = 0;
    interrupts = 0; interrupt_in_wb = 0; rfe_in_wb = 0; rfi_in_wb = 0;
    step(); step();
    chk("rst d_1", d_1, 32'h0);
    chk("rst kmode", {31'b0, kmode}, 32'h1);
    chk("rst ret_val", ret_val, 32'h0);
    chk("rst interrupt_state", interrupt_state, 32'h0);
    rst_n = 1;

    for (int a = 0; a < 32; a++) begin
      s_1 = 5'(a); s_2 = 5'(31 - a);
      step();
      $display("read r%0d/r%0d -> %h %h", a, 31 - a, d_1, d_2);
    end
    chk("post-reset d_2", d_2, 32'h0);

    we1 = 1; target_1 = 5; write_data_1 = 32'hDEADBEEF; s_1 = 5;
    step(); chk("bypass r5", d_1, 32'hDEADBEEF);
    target_1 = 0; write_data_1 = 7; s_1 = 0;
    step(); chk("r0 bypass", d_1, 32'h0);
    we1 = 0;
    step(); chk("r0 read", d_1, 32'h0);

    we1 = 1; target_1 = 3; write_data_1 = 32'h11;
    we2 = 1; target_2 = 3; write_data_2 = 32'h22; s_2 = 3;
    step(); chk("dual bypass", d_2, 32'h11);
    we2 = 0; target_1 = 1; write_data_1 = 32'h42;
    step(); chk("dual stored", d_2, 32'h11); chk("ret_val r1", ret_val, 32'h42);
    we1 = 0; s_1 = 3;
    step(); chk("r3 read", d_1, 32'h11);
    stall = 1; s_1 = 5; we1 = 1; target_1 = 3; write_data_1 = 32'h33;
    step(); chk("stall hold", d_1, 32'h11);
    we1 = 0;
    step(); chk("stall hold2", d_1, 32'h11);
    stall = 0;
    step(); chk("stall release", d_1, 32'hDEADBEEF);
    s_1 = 3;
    step(); chk("write under stall", d_1, 32'h33);
    $display("gpr section done");

    cr_we = 1; target_1 = 3; write_data_1 = 32'h8000_0005;
    step(); cr_we = 0; interrupts = 16'h0004;
    step(); chk("irq pending", interrupt_state, 32'h4);
    interrupts = 0; interrupt_in_wb = 1; epc = 32'h100; efg = 32'h7;
    step(); interrupt_in_wb = 0;
    chk("irq kmode", {31'b0, kmode}, 32'h1);
    chk("irq state off", interrupt_state, 32'h0);
    cr_s = 4; step(); chk("EPC", cr_d, 32'h100);
    cr_s = 3; step(); chk("IMR gie clr", cr_d, 32'h5);
    cr_s = 2; step(); chk("ISR ack", cr_d, 32'h0);
    rfi_in_wb = 1; cr_s = 3; step(); rfi_in_wb = 0;
    step(); chk("IMR rfi", cr_d, 32'h8000_0005);

    interrupts = 16'h0004; step();
    interrupt_in_wb = 1; step();
    interrupt_in_wb = 0; interrupts = 0; cr_s = 2;
    step(); chk("ISR repend", cr_d, 32'h4);
    rfi_in_wb = 1; step(); rfi_in_wb = 0;
    chk("repend state", interrupt_state, 32'h4);
    interrupts = 16'h0001; step(); interrupts = 0;
    interrupt_in_wb = 1; step(); interrupt_in_wb = 0;
    step(); chk("ISR highest ack", cr_d, 32'h1);
    $display("interrupt section done");

    cr_we = 1; target_1 = 0; write_data_1 = 0;
    step(); cr_we = 0; chk("user mode", {31'b0, kmode}, 32'h0);
    tlb_exc_in_wb = 1; tlb_addr = 32'hABC000;
    step(); tlb_exc_in_wb = 0; chk("tlb kmode", {31'b0, kmode}, 32'h1);
    cr_s = 7; step(); chk("TLBA", cr_d, 32'hABC000);
    rfe_in_wb = 1; step(); rfe_in_wb = 0;
    chk("rfe kmode", {31'b0, kmode}, 32'h0);

    cr_we = 1; target_1 = 6; write_data_1 = 32'h1234; cr_s = 6;
    step(); chk("CR bypass", cr_d, 32'h1234); chk("cdv", cdv, 32'h1234);
    write_data_1 = 32'h5555; exc_in_wb = 1; cr_s = 1;
    step(); exc_in_wb = 0; chk("cr_we suppressed", cdv, 32'h1234);
    target_1 = 1; write_data_1 = 32'hFFFF_FABC;
    step(); chk("pid", {20'b0, pid}, 32'hABC);
    target_1 = 9; write_data_1 = 32'h77; cr_s = 9;
    step(); chk("CR9 reads 0", cr_d, 32'h0);
    cr_we = 0;
    $display("cr section done");

    for (int i = 0; i < 16; i++) begin
      we1 = 1; target_1 = 5'((i * 3) % 32); write_data_1 = 32'(i) * 32'h0101_0101;
      we2 = 1; target_2 = 5'((i * 7) % 32); write_data_2 = ~(32'(i) * 32'h0101_0101);
      s_1 = target_1; s_2 = 5'((i * 5) % 32); cr_s = 5'(i % 8);
      step();
      $display("mix %0d: d_1=%h d_2=%h cr_d=%h", i, d_1, d_2, cr_d);
    end
    we1 = 0; we2 = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
